// File: rtl/path_job_scheduler_if.sv
// Requester / CPU / mailbox bundle for path_job_scheduler.
// The master modport is the scheduler. The slave modport is its environment: requesters, CPU and mailbox.
interface path_job_scheduler_if;
  logic [1:0]  req;
  logic [4:0]  sp0;
  logic [4:0]  ep0;
  logic [4:0]  sp1;
  logic [4:0]  ep1;
  logic        cpu_done;
  logic        cpu_reset;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic        busy;
  logic        gnt_id;

  modport master (
    input  req, sp0, ep0, sp1, ep1, cpu_done,
    output cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr, ack, err, busy, gnt_id
  );

  modport slave (
    output req, sp0, ep0, sp1, ep1, cpu_done,
    input  cpu_reset, Ext_MemWrite, Ext_WriteData, Ext_DataAdr, ack, err, busy, gnt_id
  );
endinterface

// File: rtl/path_job_scheduler.sv
// Two-requester path job scheduler: arbitrates, loads the CPU parameter mailbox while holding the CPU
// in reset, runs it until done or timeout, then acks the granted requester.
module path_job_scheduler #(
  parameter logic [31:0] BASE_ADR = 32'h0200_0000,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input logic             clk,
  input logic             reset_n,
  path_job_scheduler_if.master bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  localparam logic [23:0] TimerLast = 24'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [23:0] timer_q, timer_d;
  logic [4:0]  sp_q, sp_d;
  logic [4:0]  ep_q, ep_d;
  logic        gnt_q, gnt_d;
  logic        rr_q, rr_d;
  logic        tmo_q, tmo_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] adr_q, adr_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic        busy_q, busy_d;

  // Next-state logic; rr_q names the requester preferred when both are pending.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    timer_d = timer_q;
    sp_d    = sp_q;
    ep_d    = ep_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req != 2'b00) begin
          gnt_d   = (bus.req == 2'b11) ? rr_q : bus.req[1];
          sp_d    = gnt_d ? bus.sp1 : bus.sp0;
          ep_d    = gnt_d ? bus.ep1 : bus.ep0;
          phase_d = 3'd0;
          tmo_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (phase_q == 3'd7) begin
          timer_d = 24'd0;
          state_d = StRun;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      StRun: begin
        // A completion that lands on the terminal timer cycle is not an error.
        if (bus.cpu_done) begin
          tmo_d   = 1'b0;
          state_d = StDone;
        end else if (timer_q == TimerLast) begin
          tmo_d   = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      StDone: begin
        rr_d    = ~gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so that they come straight from flops.
  always_comb begin
    busy_d      = (state_d != StIdle);
    cpu_reset_d = (state_d != StRun);
    we_d        = (state_d == StLoad) && !phase_d[0];
    adr_d       = 32'd0;
    wdata_d     = 32'd0;
    ack_d       = 2'b00;
    err_d       = 2'b00;
    if (we_d) begin
      adr_d = BASE_ADR + {28'd0, phase_d, 1'b0};
      if (phase_d == 3'd0) begin
        wdata_d = {27'd0, sp_d};
      end else if (phase_d == 3'd2) begin
        wdata_d = {27'd0, ep_d};
      end
    end
    if (state_d == StDone) begin
      ack_d[gnt_d] = 1'b1;
      err_d[gnt_d] = tmo_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      phase_q     <= 3'd0;
      timer_q     <= 24'd0;
      sp_q        <= 5'd0;
      ep_q        <= 5'd0;
      gnt_q       <= 1'b0;
      rr_q        <= 1'b0;
      tmo_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      adr_q       <= 32'd0;
      ack_q       <= 2'b00;
      err_q       <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      timer_q     <= timer_d;
      sp_q        <= sp_d;
      ep_q        <= ep_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      tmo_q       <= tmo_d;
      cpu_reset_q <= cpu_reset_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      adr_q       <= adr_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cpu_reset     = cpu_reset_q;
  assign bus.Ext_MemWrite  = we_q;
  assign bus.Ext_WriteData = wdata_q;
  assign bus.Ext_DataAdr   = adr_q;
  assign bus.ack           = ack_q;
  assign bus.err           = err_q;
  assign bus.busy          = busy_q;
  assign bus.gnt_id        = gnt_q;

endmodule

// File: tb/tb_path_job_scheduler.sv
// Directed bench for path_job_scheduler: mailbox writes and acks are scoreboarded at negedge,
// job timing, arbitration, timeout and reset behaviour are checked inline.
module tb_path_job_scheduler;
  localparam logic [31:0] Base = 32'h0200_0000;
  localparam int          Tmo  = 16;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } wr_t;
  typedef struct packed {
    logic [1:0] ack;
    logic [1:0] err;
  } ak_t;

  logic clk;
  logic reset_n;
  int   n_pass  = 0;
  int   n_total = 0;
  wr_t  wr_q[$];
  ak_t  ak_q[$];

  path_job_scheduler_if bus ();

  path_job_scheduler #(
    .BASE_ADR (Base),
    .TIMEOUT  (Tmo)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every mailbox write and every ack must match the next queued expectation.
  always @(negedge clk) begin : mon
    wr_t we;
    ak_t ae;
    if (reset_n) begin
      if (bus.Ext_MemWrite) begin
        check("write_expected", {31'd0, wr_q.size() != 0}, 32'd1);
        if (wr_q.size() != 0) begin
          we = wr_q.pop_front();
          check("wr_adr", bus.Ext_DataAdr, we.adr);
          check("wr_data", bus.Ext_WriteData, we.data);
        end
      end
      if (bus.ack != 2'b00) begin
        check("ack_expected", {31'd0, ak_q.size() != 0}, 32'd1);
        if (ak_q.size() != 0) begin
          ae = ak_q.pop_front();
          check("sb_ack", {30'd0, bus.ack}, {30'd0, ae.ack});
          check("sb_err", {30'd0, bus.err}, {30'd0, ae.err});
        end
      end
    end
  end

  // Runs one job starting from an IDLE negedge; done_after = RUN cycle in which cpu_done pulses
  // (0 = never).
  task automatic do_job(input logic [1:0] reqv, input int done_after, input logic exp_gnt,
                        input logic exp_err, input bit drop_in_run, input bit keep_after,
                        input bit glitch_load);
    logic [4:0] s0, e0, s1, e1, sp_e, ep_e;
    logic [1:0] ack_e, err_e;
    int         n, exp_run;
    s0 = bus.sp0; e0 = bus.ep0; s1 = bus.sp1; e1 = bus.ep1;
    sp_e  = exp_gnt ? s1 : s0;
    ep_e  = exp_gnt ? e1 : e0;
    ack_e = 2'b01 << exp_gnt;
    err_e = exp_err ? ack_e : 2'b00;
    exp_run = (done_after > 0 && done_after <= Tmo) ? done_after : Tmo;
    wr_q.push_back(wr_t'({Base, 27'd0, sp_e}));
    wr_q.push_back(wr_t'({Base + 32'd4, 27'd0, ep_e}));
    wr_q.push_back(wr_t'({Base + 32'd8, 32'd0}));
    wr_q.push_back(wr_t'({Base + 32'd12, 32'd0}));
    ak_q.push_back(ak_t'({ack_e, err_e}));
    bus.req = reqv;
    @(negedge clk);
    check("grant_busy", {31'd0, bus.busy}, 32'd1);
    check("grant_id", {31'd0, bus.gnt_id}, {31'd0, exp_gnt});
    // Endpoints must have been latched at grant.
    bus.sp0 = 5'($urandom); bus.ep0 = 5'($urandom);
    bus.sp1 = 5'($urandom); bus.ep1 = 5'($urandom);
    n = 0;
    while (bus.cpu_reset && n < 20) begin
      if (n % 2 == 1) begin
        check("odd_phase_we", {31'd0, bus.Ext_MemWrite}, 32'd0);
        check("odd_phase_adr", bus.Ext_DataAdr, 32'd0);
      end
      bus.cpu_done = glitch_load && (n == 3);
      n++;
      @(negedge clk);
    end
    bus.cpu_done = 1'b0;
    check("load_cycles", n, 32'd8);
    check("run_we", {31'd0, bus.Ext_MemWrite}, 32'd0);
    check("run_wdata", bus.Ext_WriteData, 32'd0);
    if (drop_in_run) bus.req = 2'b00;
    n = 0;
    while (!bus.cpu_reset && n < 40) begin
      n++;
      bus.cpu_done = (n == done_after);
      @(negedge clk);
    end
    bus.cpu_done = 1'b0;
    check("run_cycles", n, exp_run);
    check("done_ack", {30'd0, bus.ack}, {30'd0, ack_e});
    check("done_err", {30'd0, bus.err}, {30'd0, err_e});
    check("done_busy", {31'd0, bus.busy}, 32'd1);
    if (!keep_after) bus.req = 2'b00;
    bus.sp0 = s0; bus.ep0 = e0; bus.sp1 = s1; bus.ep1 = e1;
    @(negedge clk);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_ack", {30'd0, bus.ack}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    bus.req      = 2'b00;
    bus.cpu_done = 1'b0;
    bus.sp0 = 5'd3; bus.ep0 = 5'd17;
    bus.sp1 = 5'd9; bus.ep1 = 5'd30;
    @(negedge clk);
    check("rst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
    check("rst_we", {31'd0, bus.Ext_MemWrite}, 32'd0);
    check("rst_adr", bus.Ext_DataAdr, 32'd0);
    check("rst_wdata", bus.Ext_WriteData, 32'd0);
    check("rst_ack_err", {28'd0, bus.ack, bus.err}, 32'd0);
    check("rst_busy_gnt", {30'd0, bus.busy, bus.gnt_id}, 32'd0);
    reset_n = 1'b1;

    // Both pending from reset: 0 first, then alternate.
    do_job(2'b11, 6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_job(2'b11, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_job(2'b11, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // cpu_done in IDLE is ignored.
    bus.cpu_done = 1'b1;
    @(negedge clk);
    bus.cpu_done = 1'b0;
    check("idle_done_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_done_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);

    // Basic job with a cpu_done glitch during LOAD.
    do_job(2'b01, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Timeout on requester 1.
    do_job(2'b10, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // cpu_done on the terminal timer cycle: no error.
    do_job(2'b01, Tmo, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Same requester back-to-back with req held.
    do_job(2'b01, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_job(2'b01, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // req dropped during RUN still completes.
    do_job(2'b10, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in LOAD phase 3 abandons the job; held req restarts it afterwards.
    wr_q.push_back(wr_t'({Base, 27'd0, bus.sp1}));
    wr_q.push_back(wr_t'({Base + 32'd4, 27'd0, bus.ep1}));
    bus.req = 2'b10;
    @(negedge clk);
    check("abort_grant_id", {31'd0, bus.gnt_id}, 32'd1);
    repeat (3) @(negedge clk);
    check("abort_phase3_busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
    check("abort_we", {31'd0, bus.Ext_MemWrite}, 32'd0);
    check("abort_gnt_id", {31'd0, bus.gnt_id}, 32'd0);
    check("abort_ack", {30'd0, bus.ack}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_job(2'b10, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("wr_q_drained", wr_q.size(), 32'd0);
    check("ak_q_drained", ak_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
